// File: rtl/compound_peer.sv
// compound_peer: burst request/response initiator; optional watchdog enabled by COMPOUND_PEER_TIMEOUT_EN
package compound_peer_pkg;
    typedef enum logic {MODE_READ = 1'b0, MODE_WRITE = 1'b1} mode_e;
    typedef struct packed {
        mode_e              mode;
        logic signed [31:0] x;
        logic               y;
    } compound_t;
endpackage

module compound_peer
    import compound_peer_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] num_txn,
    input  logic [31:0] base_x,
    output compound_t  req_out,
    output logic       req_out_notify,
    input  logic       req_out_sync,
    input  compound_t  rsp_in,
    input  logic       rsp_in_sync,
    output logic       rsp_in_notify,
    output logic       busy,
    output logic       done,
    output logic [7:0] rsp_count,
    output compound_t  last_rsp,
    output logic       timeout
);
    typedef enum logic [1:0] {IDLE, SEND, RECV, DONE} state_e;

    state_e     state_q, state_d;
    compound_t  req_q, req_d, last_q, last_d;
    logic [7:0] cnt_q, cnt_d, num_q, num_d, nxt;
    logic [31:0] base_q, base_d;
`ifdef COMPOUND_PEER_TIMEOUT_EN
    logic [4:0] wait_q, wait_d;
    logic       timeout_q, timeout_d;
`endif

    // next state, next request payload and response capture
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        num_d   = num_q;
        base_d  = base_q;
        nxt     = cnt_q + 8'd1;
        case (state_q)
            IDLE: if (start) begin
                num_d      = num_txn;
                base_d     = base_x;
                cnt_d      = 8'd0;
                req_d.mode = MODE_READ;
                req_d.x    = base_x;
                req_d.y    = num_txn == 8'd1;
                state_d    = num_txn == 8'd0 ? DONE : SEND;
            end
            SEND: state_d = req_out_sync ? RECV : SEND;
            RECV: if (rsp_in_sync) begin
                last_d     = rsp_in;
                cnt_d      = nxt;
                req_d.mode = nxt[0] ? MODE_WRITE : MODE_READ;
                req_d.x    = base_q + {24'd0, nxt};
                req_d.y    = nxt == num_q - 8'd1;
                state_d    = nxt < num_q ? SEND : DONE;
            end
            default: state_d = IDLE;
        endcase
`ifdef COMPOUND_PEER_TIMEOUT_EN
        timeout_d = (state_q == IDLE && start) ? 1'b0 : timeout_q;
        wait_d    = 5'd0;
        if ((state_q == SEND && !req_out_sync) || (state_q == RECV && !rsp_in_sync)) begin
            wait_d = wait_q + 5'd1;
            if (wait_d == 5'd16) begin
                state_d   = DONE;
                timeout_d = 1'b1;
            end
        end
`endif
    end

    // state and payload registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            req_q   <= '0;
            last_q  <= '0;
            cnt_q   <= 8'd0;
            num_q   <= 8'd0;
            base_q  <= 32'd0;
`ifdef COMPOUND_PEER_TIMEOUT_EN
            wait_q    <= 5'd0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            num_q   <= num_d;
            base_q  <= base_d;
`ifdef COMPOUND_PEER_TIMEOUT_EN
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    assign req_out        = req_q;
    assign req_out_notify = state_q == SEND;
    assign rsp_in_notify  = state_q == RECV;
    assign busy           = state_q == SEND || state_q == RECV;
    assign done           = state_q == DONE;
    assign rsp_count      = cnt_q;
    assign last_rsp       = last_q;
`ifdef COMPOUND_PEER_TIMEOUT_EN
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif
endmodule

// File: tb/tb_compound_peer.sv
// tb_compound_peer: directed scoreboard bench for compound_peer
module tb_compound_peer;
    import compound_peer_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] num_txn = 8'd0;
    logic [31:0] base_x = 32'd0;
    compound_t  req_out, rsp_in, last_rsp;
    logic       req_out_notify, req_out_sync = 1'b0;
    logic       rsp_in_sync = 1'b0, rsp_in_notify;
    logic       busy, done, timeout;
    logic [7:0] rsp_count;

    int checks = 0;
    int failures = 0;
    int req_xfers = 0;
    int rsp_xfers = 0;
    int done_cnt = 0;
    int b_req, b_rsp, b_done;
    compound_t exp_q[$];

    compound_peer dut (
        .clk(clk), .rst(rst), .start(start), .num_txn(num_txn), .base_x(base_x),
        .req_out(req_out), .req_out_notify(req_out_notify), .req_out_sync(req_out_sync),
        .rsp_in(rsp_in), .rsp_in_sync(rsp_in_sync), .rsp_in_notify(rsp_in_notify),
        .busy(busy), .done(done), .rsp_count(rsp_count), .last_rsp(last_rsp), .timeout(timeout)
    );

    always #5 clk = ~clk;

    function automatic compound_t mk(input mode_e m, input logic [31:0] x, input logic y);
        compound_t c;
        c.mode = m;
        c.x = x;
        c.y = y;
        return c;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        cyc();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 100);
        check(nm, 64'(done), 64'd1);
    endtask

    task automatic snap();
        b_req = req_xfers;
        b_rsp = rsp_xfers;
        b_done = done_cnt;
    endtask

    task automatic check_reset(input string nm);
        check({nm, "_req_out"}, 64'(req_out), 64'd0);
        check({nm, "_notify"}, 64'({req_out_notify, rsp_in_notify}), 64'd0);
        check({nm, "_busy_done"}, 64'({busy, done}), 64'd0);
        check({nm, "_rsp_count"}, 64'(rsp_count), 64'd0);
        check({nm, "_last_rsp"}, 64'(last_rsp), 64'd0);
        check({nm, "_timeout"}, 64'(timeout), 64'd0);
    endtask

    // monitor: scoreboard pop on every request transfer, transfer and done accounting
    always @(negedge clk) begin
        if (!rst) begin
            if (req_out_notify && rsp_in_notify) begin
                checks++;
                failures++;
                $display("FAIL both_notify: got 1 expected 0");
            end
            if (req_out_notify && req_out_sync) begin
                req_xfers++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL req_unexpected: got 0x%0h expected none", req_out);
                end else
                    check("req_payload", 64'(req_out), 64'(exp_q.pop_front()));
            end
            if (rsp_in_notify && rsp_in_sync) rsp_xfers++;
            if (done) done_cnt++;
        end
    end

    initial begin
        rsp_in = mk(MODE_WRITE, 32'h55, 1'b1);
        repeat (2) cyc();
        rst = 1'b0;
        @(negedge clk);
        check_reset("reset");

        // three back-to-back transactions with always-ready partner
        num_txn = 8'd3;
        base_x = 32'd10;
        req_out_sync = 1'b1;
        rsp_in_sync = 1'b1;
        exp_q.push_back(mk(MODE_READ, 32'd10, 1'b0));
        exp_q.push_back(mk(MODE_WRITE, 32'd11, 1'b0));
        exp_q.push_back(mk(MODE_READ, 32'd12, 1'b1));
        snap();
        pulse_start();
        @(negedge clk);
        check("s1_notify_first", 64'({req_out_notify, busy}), 64'b11);
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("s1_req_xfers", 64'(req_xfers - b_req), 64'd3);
        check("s1_rsp_xfers", 64'(rsp_xfers - b_rsp), 64'd3);
        check("s1_done", 64'({done, busy}), 64'b10);
        check("s1_rsp_count", 64'(rsp_count), 64'd3);
        cyc();
        cyc();
        @(negedge clk);
        check("s1_done_once", 64'(done_cnt - b_done), 64'd1);
        check("s1_last_rsp_held", 64'(last_rsp), 64'(mk(MODE_WRITE, 32'h55, 1'b1)));

        // partner stalls the request for five cycles
        num_txn = 8'd1;
        base_x = 32'd100;
        req_out_sync = 1'b0;
        exp_q.push_back(mk(MODE_READ, 32'd100, 1'b1));
        snap();
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("s2_stall_notify", 64'(req_out_notify), 64'd1);
            check("s2_stall_payload", 64'(req_out), 64'(mk(MODE_READ, 32'd100, 1'b1)));
            cyc();
        end
        req_out_sync = 1'b1;
        wait_done("s2_done");
        check("s2_req_xfers", 64'(req_xfers - b_req), 64'd1);
        check("s2_rsp_count", 64'(rsp_count), 64'd1);

        // x wraps from max positive to min negative
        cyc();
        num_txn = 8'd2;
        base_x = 32'h7FFFFFFF;
        exp_q.push_back(mk(MODE_READ, 32'h7FFFFFFF, 1'b0));
        exp_q.push_back(mk(MODE_WRITE, 32'h80000000, 1'b1));
        pulse_start();
        wait_done("s3_done");
        check("s3_rsp_count", 64'(rsp_count), 64'd2);
        check("s3_queue_empty", 64'(exp_q.size()), 64'd0);

        // zero-length burst
        cyc();
        num_txn = 8'd0;
        snap();
        pulse_start();
        @(negedge clk);
        check("s4_done", 64'(done), 64'd1);
        check("s4_no_notify", 64'({req_out_notify, rsp_in_notify, busy}), 64'd0);
        check("s4_rsp_count", 64'(rsp_count), 64'd0);
        cyc();
        @(negedge clk);
        check("s4_done_cleared", 64'(done), 64'd0);
        check("s4_no_xfers", 64'((req_xfers - b_req) + (rsp_xfers - b_rsp)), 64'd0);

        // start ignored while busy, inputs changed mid-burst, then reset in RECV
        cyc();
        num_txn = 8'd2;
        base_x = 32'd20;
        req_out_sync = 1'b1;
        rsp_in_sync = 1'b0;
        exp_q.push_back(mk(MODE_READ, 32'd20, 1'b0));
        snap();
        pulse_start();
        num_txn = 8'd5;
        base_x = 32'd999;
        cyc();
        start = 1'b1;
        cyc();
        start = 1'b0;
        @(negedge clk);
        check("s5_still_recv", 64'({busy, rsp_in_notify, req_out_notify}), 64'b110);
        check("s5_rsp_count0", 64'(rsp_count), 64'd0);
        exp_q.push_back(mk(MODE_WRITE, 32'd21, 1'b1));
        rsp_in = mk(MODE_READ, 32'h1234, 1'b0);
        rsp_in_sync = 1'b1;
        cyc();
        rsp_in_sync = 1'b0;
        @(negedge clk);
        check("s5_rsp_count1", 64'(rsp_count), 64'd1);
        check("s5_last_rsp", 64'(last_rsp), 64'(mk(MODE_READ, 32'h1234, 1'b0)));
        cyc();
        @(negedge clk);
        check("s5_in_recv", 64'(rsp_in_notify), 64'd1);
        rst = 1'b1;
        start = 1'b1;
        rsp_in_sync = 1'b1;
        cyc();
        rst = 1'b0;
        start = 1'b0;
        rsp_in_sync = 1'b0;
        @(negedge clk);
        check_reset("s5_reset");
        repeat (3) cyc();
        @(negedge clk);
        check("s5_no_done", 64'(done_cnt - b_done), 64'd0);
        check("s5_queue_empty", 64'(exp_q.size()), 64'd0);

`ifdef COMPOUND_PEER_TIMEOUT_EN
        // watchdog fires in RECV when the partner never responds
        num_txn = 8'd2;
        base_x = 32'd5;
        req_out_sync = 1'b1;
        rsp_in_sync = 1'b0;
        exp_q.push_back(mk(MODE_READ, 32'd5, 1'b0));
        pulse_start();
        repeat (16) @(posedge clk);
        @(negedge clk);
        check("s6_wait_16", 64'({rsp_in_notify, done, timeout}), 64'b100);
        @(posedge clk);
        @(negedge clk);
        check("s6_timeout_done", 64'({rsp_in_notify, done, timeout}), 64'b011);
        check("s6_rsp_count", 64'(rsp_count), 64'd0);
        cyc();
        @(negedge clk);
        check("s6_sticky", 64'({done, timeout}), 64'b01);
        num_txn = 8'd0;
        pulse_start();
        @(negedge clk);
        check("s6_timeout_clear", 64'(timeout), 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
